// File: rtl/roleda_deser.sv
// Serial-to-parallel front end for the 5-bit pattern detector.
// Collects gated serial bits into 5-bit frames and keeps a registered match plus saturating counters.
module roleda_deser #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SIN,
    input  logic             SIN_VALID,
    input  logic             SYNC,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             D,
    output logic             E,
    output logic             VALID,
    output logic             MATCH,
    output logic [CNT_W-1:0] FRAME_CNT,
    output logic [CNT_W-1:0] MATCH_CNT
);

    typedef enum logic [0:0] {StCollect, StComplete} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e     state_q;
    logic [2:0] idx_q;
    logic [3:0] sr_q;
    logic [4:0] frame;
    logic       frame_match;

    always_comb begin
        frame       = {sr_q, SIN};
        frame_match = (frame == 5'b10110) || (frame == 5'b11010);
    end

    // StComplete lasts exactly the one cycle after a frame lands, so VALID is a state decode.
    assign VALID = (state_q == StComplete);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StCollect;
            idx_q     <= 3'd0;
            sr_q      <= 4'd0;
            {A, B, C, D, E} <= 5'd0;
            MATCH     <= 1'b0;
            FRAME_CNT <= '0;
            MATCH_CNT <= '0;
        end else begin
            state_q <= StCollect;
            if (SYNC) begin
                // Realign: a qualified bit in the same cycle starts the new frame.
                sr_q  <= {3'd0, SIN & SIN_VALID};
                idx_q <= SIN_VALID ? 3'd1 : 3'd0;
            end else if (SIN_VALID) begin
                if (idx_q == 3'd4) begin
                    state_q         <= StComplete;
                    idx_q           <= 3'd0;
                    sr_q            <= 4'd0;
                    {A, B, C, D, E} <= frame;
                    MATCH           <= frame_match;
                    if (FRAME_CNT != CntMax) begin
                        FRAME_CNT <= FRAME_CNT + CntOne;
                    end
                    if (frame_match && (MATCH_CNT != CntMax)) begin
                        MATCH_CNT <= MATCH_CNT + CntOne;
                    end
                end else begin
                    sr_q  <= {sr_q[2:0], SIN};
                    idx_q <= idx_q + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_roleda_deser.sv
// Bench for roleda_deser: directed steps then random traffic against a queue-based frame model.
// Two instances (CNT_W=8 and CNT_W=2) share stimulus so saturation is visible on the narrow one.
module tb_roleda_deser;

    logic       clk;
    logic       rst;
    logic       SIN;
    logic       SIN_VALID;
    logic       SYNC;
    logic       a8, b8, c8, d8, e8, valid8, match8;
    logic [7:0] fc8, mc8;
    logic       a2, b2, c2, d2, e2, valid2, match2;
    logic [1:0] fc2, mc2;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit   bits_q[$];
    logic [4:0] exp_frame = 5'd0;
    logic exp_valid = 1'b0;
    logic exp_match = 1'b0;
    int   exp_fc = 0;
    int   exp_mc = 0;

    roleda_deser #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .SIN(SIN), .SIN_VALID(SIN_VALID), .SYNC(SYNC),
        .A(a8), .B(b8), .C(c8), .D(d8), .E(e8), .VALID(valid8), .MATCH(match8),
        .FRAME_CNT(fc8), .MATCH_CNT(mc8)
    );

    roleda_deser #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .SIN(SIN), .SIN_VALID(SIN_VALID), .SYNC(SYNC),
        .A(a2), .B(b2), .C(c2), .D(d2), .E(e2), .VALID(valid2), .MATCH(match2),
        .FRAME_CNT(fc2), .MATCH_CNT(mc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat(input int c, input int w);
        int m;
        m = (1 << w) - 1;
        return (c > m) ? m : c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic s, input logic sv, input logic sy, input logic r);
        exp_valid = 1'b0;
        if (r) begin
            bits_q.delete();
            exp_frame = 5'd0;
            exp_match = 1'b0;
            exp_fc    = 0;
            exp_mc    = 0;
        end else if (sy) begin
            bits_q.delete();
            if (sv) bits_q.push_back(s);
        end else if (sv) begin
            bits_q.push_back(s);
            if (bits_q.size() == 5) begin
                for (int i = 0; i < 5; i++) exp_frame[4-i] = bits_q[i];
                exp_match = (exp_frame == 5'b10110) || (exp_frame == 5'b11010);
                exp_valid = 1'b1;
                exp_fc++;
                if (exp_match) exp_mc++;
                bits_q.delete();
            end
        end
    endtask

    task automatic step(input logic s, input logic sv, input logic sy, input logic r);
        SIN       = s;
        SIN_VALID = sv;
        SYNC      = sy;
        rst       = r;
        @(posedge clk);
        model_update(s, sv, sy, r);
        #1;
        chk("valid8", 32'(valid8), 32'(exp_valid));
        chk("abcde8", 32'({a8, b8, c8, d8, e8}), 32'(exp_frame));
        chk("match8", 32'(match8), 32'(exp_match));
        chk("frame_cnt8", 32'(fc8), 32'(sat(exp_fc, 8)));
        chk("match_cnt8", 32'(mc8), 32'(sat(exp_mc, 8)));
        chk("valid2", 32'(valid2), 32'(exp_valid));
        chk("abcde2", 32'({a2, b2, c2, d2, e2}), 32'(exp_frame));
        chk("frame_cnt2", 32'(fc2), 32'(sat(exp_fc, 2)));
        chk("match_cnt2", 32'(mc2), 32'(sat(exp_mc, 2)));
    endtask

    task automatic send5(input logic [4:0] f);
        for (int i = 4; i >= 0; i--) step(f[i], 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step($urandom_range(0, 1), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        SIN = 1'b0; SIN_VALID = 1'b0; SYNC = 1'b0; rst = 1'b1;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);

        // Single matching frame, then hold
        send5(5'b10110);
        idle(3);

        // Gapped frame 11010, then non-matching 00001
        begin
            logic [4:0] f;
            f = 5'b11010;
            for (int i = 4; i >= 0; i--) begin
                step(f[i], 1'b1, 1'b0, 1'b0);
                if (i != 0) idle(2);
            end
        end
        send5(5'b00001);
        idle(2);

        // SYNC with a qualified bit restarts the frame
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // SYNC on the 5th bit aborts; that bit is bit 0 of the next frame
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Back-to-back frames saturate the narrow counters
        for (int k = 0; k < 5; k++) send5(5'b10110);
        idle(1);

        // Reset mid-frame, then a clean match frame
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send5(5'b10110);
        idle(1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
